wb_port_arbiter: RTL and testbench

//  Shares the register file's single write port between two producers: the ALU writeback stage and the load/store unit (LSU).

---
 rtl/rf_pkg.sv | 24 ++
 rtl/wb_scoreboard.sv | 56 +++++
 rtl/wb_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
//   Shared definitions for the register-file writeback path: default widths,
//   register count, the writeback source enum and a writeback request struct.
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;
    localparam int NUM_REGS      = 32;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU
    } wb_src_e;

    typedef struct packed {
        logic                     valid;
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
//   Pending-load scoreboard: one bit per architectural register, set when a
//   load is issued to that register and cleared when the load data is written
//   back. Register 0 is hardwired to "not busy".
// Ports
//   clk, rst   clock and synchronous active-high reset
//   set_en     load issued this cycle
//   set_rd     destination of the issued load
//   clr_en     load data written back this cycle
//   clr_rd     destination of the written-back load
//   busy       pending-load mask (registered)
// ---------------------------------------------------------------------------
module wb_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_WIDTH-1:0]    set_rd,
    input  logic                     clr_en,
    input  logic [ADDR_WIDTH-1:0]    clr_rd,
    output logic [2**ADDR_WIDTH-1:0] busy
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_q;

    // Clear is applied before set so that a new load issued to the register
    // whose previous load is completing this cycle keeps it marked pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != '0)) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the register file's single write port between the ALU writeback
//   stage and the load/store unit. The LSU wins by default; after
//   STARVE_LIMIT consecutive losses the ALU is forced to win once. The
//   winning write is staged one cycle in WEN/RD_SEL/WB_DATA. A pending-load
//   scoreboard (BUSY) lets issue logic stall on read-after-write hazards.
// Ports
//   CLK, RESET               clock, synchronous active-high reset
//   ALU_VALID/READY/RD/DATA  ALU writeback request and combinational grant
//   LSU_VALID/READY/RD/DATA  load writeback request and combinational grant
//   LSU_ISSUE, LSU_ISSUE_RD  load issue, marks destination pending
//   BUSY                     pending-load mask, bit 0 always 0
//   WEN, RD_SEL, WB_DATA     staged register-file write (registered)
// Configuration
//   WB_BYPASS_EN  adds RS1_SEL/RS2_SEL inputs and FWD1_HIT/FWD2_HIT/FWD_DATA
//                 outputs so decode can consume the staged write one cycle
//                 before the register file commits it.
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH   = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = RF_DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ALU_VALID,
    output logic                     ALU_READY,
    input  logic [ADDR_WIDTH-1:0]    ALU_RD,
    input  logic [DATA_WIDTH-1:0]    ALU_DATA,
    input  logic                     LSU_VALID,
    output logic                     LSU_READY,
    input  logic [ADDR_WIDTH-1:0]    LSU_RD,
    input  logic [DATA_WIDTH-1:0]    LSU_DATA,
    input  logic                     LSU_ISSUE,
    input  logic [ADDR_WIDTH-1:0]    LSU_ISSUE_RD,
    output logic [2**ADDR_WIDTH-1:0] BUSY,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0]    RS1_SEL,
    input  logic [ADDR_WIDTH-1:0]    RS2_SEL,
    output logic                     FWD1_HIT,
    output logic                     FWD2_HIT,
    output logic [DATA_WIDTH-1:0]    FWD_DATA,
`endif
    output logic                     WEN,
    output logic [ADDR_WIDTH-1:0]    RD_SEL,
    output logic [DATA_WIDTH-1:0]    WB_DATA
);

    // STARVE_LIMIT is bounded to 1..15, so four bits always suffice.
    localparam int                CNT_W = 4;
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    wb_src_e                 src;
    logic [CNT_W-1:0]        starve_cnt_d, starve_cnt_q;
    logic                    wen_d, wen_q;
    logic [ADDR_WIDTH-1:0]   rd_sel_d, rd_sel_q;
    logic [DATA_WIDTH-1:0]   wb_data_d, wb_data_q;

    // Grant: LSU by default, ALU when the LSU is idle or the ALU has lost
    // STARVE_LIMIT times in a row.
    always_comb begin
        src = SRC_NONE;
        if (ALU_VALID && (!LSU_VALID || (starve_cnt_q == LIMIT))) begin
            src = SRC_ALU;
        end else if (LSU_VALID) begin
            src = SRC_LSU;
        end
    end

    assign ALU_READY = (src == SRC_ALU);
    assign LSU_READY = (src == SRC_LSU);

    // Counts only losses while the ALU is actually waiting; any other cycle
    // breaks the streak.
    always_comb begin
        starve_cnt_d = '0;
        if (ALU_VALID && (src == SRC_LSU)) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // Index and data hold when nothing transfers; only WEN drops. Writes to
    // register 0 are accepted but never enabled.
    always_comb begin
        wen_d     = 1'b0;
        rd_sel_d  = rd_sel_q;
        wb_data_d = wb_data_q;
        case (src)
            SRC_ALU: begin
                wen_d     = (ALU_RD != '0);
                rd_sel_d  = ALU_RD;
                wb_data_d = ALU_DATA;
            end
            SRC_LSU: begin
                wen_d     = (LSU_RD != '0);
                rd_sel_d  = LSU_RD;
                wb_data_d = LSU_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt_q <= '0;
            wen_q        <= 1'b0;
            rd_sel_q     <= '0;
            wb_data_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wen_q        <= wen_d;
            rd_sel_q     <= rd_sel_d;
            wb_data_q    <= wb_data_d;
        end
    end

    wb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk    (CLK),
        .rst    (RESET),
        .set_en (LSU_ISSUE),
        .set_rd (LSU_ISSUE_RD),
        .clr_en (src == SRC_LSU),
        .clr_rd (LSU_RD),
        .busy   (BUSY)
    );

    assign WEN     = wen_q;
    assign RD_SEL  = rd_sel_q;
    assign WB_DATA = wb_data_q;

`ifdef WB_BYPASS_EN
    assign FWD1_HIT = wen_q && (rd_sel_q == RS1_SEL) && (RS1_SEL != '0);
    assign FWD2_HIT = wen_q && (rd_sel_q == RS2_SEL) && (RS2_SEL != '0);
    assign FWD_DATA = wb_data_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    import rf_pkg::*;

    localparam int AW    = RF_ADDR_WIDTH;
    localparam int DW    = RF_DATA_WIDTH;
    localparam int LIMIT = 4;

    logic              CLK;
    logic              RESET;
    logic              ALU_VALID, ALU_READY;
    logic [AW-1:0]     ALU_RD;
    logic [DW-1:0]     ALU_DATA;
    logic              LSU_VALID, LSU_READY;
    logic [AW-1:0]     LSU_RD;
    logic [DW-1:0]     LSU_DATA;
    logic              LSU_ISSUE;
    logic [AW-1:0]     LSU_ISSUE_RD;
    logic [NUM_REGS-1:0] BUSY;
    logic              WEN;
    logic [AW-1:0]     RD_SEL;
    logic [DW-1:0]     WB_DATA;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]     RS1_SEL, RS2_SEL;
    logic              FWD1_HIT, FWD2_HIT;
    logic [DW-1:0]     FWD_DATA;
`endif

    wb_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ALU_VALID    (ALU_VALID),
        .ALU_READY    (ALU_READY),
        .ALU_RD       (ALU_RD),
        .ALU_DATA     (ALU_DATA),
        .LSU_VALID    (LSU_VALID),
        .LSU_READY    (LSU_READY),
        .LSU_RD       (LSU_RD),
        .LSU_DATA     (LSU_DATA),
        .LSU_ISSUE    (LSU_ISSUE),
        .LSU_ISSUE_RD (LSU_ISSUE_RD),
        .BUSY         (BUSY),
`ifdef WB_BYPASS_EN
        .RS1_SEL      (RS1_SEL),
        .RS2_SEL      (RS2_SEL),
        .FWD1_HIT     (FWD1_HIT),
        .FWD2_HIT     (FWD2_HIT),
        .FWD_DATA     (FWD_DATA),
`endif
        .WEN          (WEN),
        .RD_SEL       (RD_SEL),
        .WB_DATA      (WB_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One expected observation per cycle: grants for the inputs applied this
    // cycle plus the registered outputs visible during this cycle.
    typedef struct packed {
        logic                alu_rdy;
        logic                lsu_rdy;
        logic                wen;
        logic [AW-1:0]       rd;
        logic [DW-1:0]       data;
        logic [NUM_REGS-1:0] busy;
        logic                f1;
        logic                f2;
        logic [DW-1:0]       fdata;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: what the register-file port and load tracker
    // should look like after the most recent clock edge.
    bit                  m_wen    = 1'b0;
    logic [AW-1:0]       m_rd     = '0;
    logic [DW-1:0]       m_data   = '0;
    logic [NUM_REGS-1:0] m_busy   = '0;
    int                  m_losses = 0;

    function automatic wb_req_t req(input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        wb_req_t r;
        r.valid = v;
        r.rd    = rd;
        r.data  = d;
        return r;
    endfunction

    task automatic step(input bit rst, input wb_req_t a, input wb_req_t l,
                        input bit iss, input logic [AW-1:0] issrd,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        obs_t e;
        bit   ar, lr;
        @(posedge CLK);
        #1;
        RESET        = rst;
        ALU_VALID    = a.valid;
        ALU_RD       = a.rd;
        ALU_DATA     = a.data;
        LSU_VALID    = l.valid;
        LSU_RD       = l.rd;
        LSU_DATA     = l.data;
        LSU_ISSUE    = iss;
        LSU_ISSUE_RD = issrd;
`ifdef WB_BYPASS_EN
        RS1_SEL      = rs1;
        RS2_SEL      = rs2;
`endif
        ar = a.valid && (!l.valid || (m_losses == LIMIT));
        lr = l.valid && !ar;
        e.alu_rdy = ar;
        e.lsu_rdy = lr;
        e.wen     = m_wen;
        e.rd      = m_rd;
        e.data    = m_data;
        e.busy    = m_busy;
`ifdef WB_BYPASS_EN
        e.f1      = m_wen && (m_rd == rs1) && (rs1 != 0);
        e.f2      = m_wen && (m_rd == rs2) && (rs2 != 0);
        e.fdata   = m_data;
`else
        e.f1      = 1'b0;
        e.f2      = 1'b0;
        e.fdata   = '0;
`endif
        exp_q.push_back(e);

        if (rst) begin
            m_wen    = 1'b0;
            m_rd     = '0;
            m_data   = '0;
            m_busy   = '0;
            m_losses = 0;
        end else begin
            if (ar) begin
                m_wen = (a.rd != 0); m_rd = a.rd; m_data = a.data;
            end else if (lr) begin
                m_wen = (l.rd != 0); m_rd = l.rd; m_data = l.data;
            end else begin
                m_wen = 1'b0;
            end
            if (a.valid && lr) m_losses = (m_losses < LIMIT) ? m_losses + 1 : LIMIT;
            else               m_losses = 0;
            if (lr) m_busy[l.rd] = 1'b0;
            if (iss && issrd != 0) m_busy[issrd] = 1'b1;
        end
    endtask

    // Monitor: compares the DUT against the oldest expectation mid-cycle.
    always @(negedge CLK) begin : monitor
        obs_t e, act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act.alu_rdy = ALU_READY;
            act.lsu_rdy = LSU_READY;
            act.wen     = WEN;
            act.rd      = RD_SEL;
            act.data    = WB_DATA;
            act.busy    = BUSY;
`ifdef WB_BYPASS_EN
            act.f1      = FWD1_HIT;
            act.f2      = FWD2_HIT;
            act.fdata   = FWD_DATA;
`else
            act.f1      = 1'b0;
            act.f2      = 1'b0;
            act.fdata   = '0;
`endif
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t: got rdy(a,l)=%b%b wen=%b rd=%0d data=%h busy=%h fwd=%b%b/%h ; want rdy(a,l)=%b%b wen=%b rd=%0d data=%h busy=%h fwd=%b%b/%h",
                         vectors, $time, act.alu_rdy, act.lsu_rdy, act.wen, act.rd, act.data, act.busy,
                         act.f1, act.f2, act.fdata, e.alu_rdy, e.lsu_rdy, e.wen, e.rd, e.data, e.busy,
                         e.f1, e.f2, e.fdata);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        wb_req_t idle;
        wb_req_t a, l;
        idle = req(1'b0, '0, '0);

        RESET = 1'b1;
        ALU_VALID = 1'b0; ALU_RD = '0; ALU_DATA = '0;
        LSU_VALID = 1'b0; LSU_RD = '0; LSU_DATA = '0;
        LSU_ISSUE = 1'b0; LSU_ISSUE_RD = '0;
`ifdef WB_BYPASS_EN
        RS1_SEL = '0; RS2_SEL = '0;
`endif
        repeat (2) @(posedge CLK);

        // Reset state, then single ALU write with the LSU idle.
        step(0, idle, idle, 0, 0, 0, 0);
        step(0, req(1, 5, 32'hDEADBEEF), idle, 0, 0, 0, 0);
        step(0, idle, idle, 0, 0, 5, 0);

        // Both requesters held high: L,L,L,L,A,L,L,L,L,A.
        for (int i = 0; i < 10; i++)
            step(0, req(1, AW'(10 + i), $urandom), req(1, AW'(20 + i), $urandom), 0, 0, 0, 0);
        step(0, idle, idle, 0, 0, 0, 0);

        // Scoreboard set, clear, and simultaneous set+clear on register 7.
        step(0, idle, idle, 1, 7, 0, 0);
        step(0, idle, idle, 0, 0, 0, 0);
        step(0, idle, req(1, 7, 32'h0000_0777), 0, 0, 0, 0);
        step(0, idle, idle, 1, 7, 0, 0);
        step(0, idle, req(1, 7, 32'h0000_0778), 1, 7, 0, 0);
        step(0, idle, idle, 1, 7, 0, 0);
        step(0, idle, idle, 0, 0, 0, 0);

        // Register 0: accepted but never written, never marked busy.
        step(0, req(1, 0, 32'h0000_1234), idle, 0, 0, 0, 0);
        step(0, idle, idle, 1, 0, 0, 0);
        step(0, idle, idle, 0, 0, 0, 0);

        // Staged write to 9 observed with source selects 9 and 3.
        step(0, req(1, 9, 32'hCAFE_0009), idle, 0, 0, 0, 0);
        step(0, idle, idle, 0, 0, 9, 3);
        step(0, idle, idle, 0, 0, 9, 9);

        // Traffic with pending loads, then reset held for two cycles.
        for (int i = 0; i < 6; i++)
            step(0, req(1, AW'(i + 1), $urandom), req(1, AW'(i + 2), $urandom), 1, AW'(i + 3), 0, 0);
        step(1, req(1, 3, $urandom), req(1, 4, $urandom), 1, 5, 0, 0);
        step(1, req(1, 3, $urandom), req(1, 4, $urandom), 1, 6, 0, 0);
        step(0, idle, idle, 0, 0, 0, 0);
        step(0, idle, idle, 0, 0, 0, 0);

        // Randomized traffic; small register range provokes index collisions.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra, rl, ri, s1, s2;
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            ra = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rl = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ri = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            s1 = AW'($urandom_range(0, 7));
            s2 = AW'($urandom_range(0, 7));
            a = req($urandom_range(0, 9) < 6, ra, $urandom);
            l = req($urandom_range(0, 9) < 6, rl, $urandom);
            step($urandom_range(0, 59) == 0, a, l, $urandom_range(0, 9) < 3, ri, s1, s2);
        end
        step(0, idle, idle, 0, 0, 0, 0);

        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
